// File: rtl/chess_clock_turn_ctrl.sv
// Chess clock turn controller: debounced move/pause buttons, game FSM, move counter, loser latch.
// Optional pause support is built when CHESS_CLOCK_PAUSE_EN is defined.

module chess_clock_debounce #(
  parameter int p_debounce = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);
  localparam int CW = (p_debounce < 2) ? 1 : $clog2(p_debounce);
  localparam logic [CW-1:0] CMAX = CW'(p_debounce - 1);

  logic          r_s1, r_s2, r_deb, r_deb_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      // Flip on the p_debounce-th consecutive differing sample.
      if (r_s2 != r_deb) begin
        if (r_cnt == CMAX) begin
          r_deb <= ~r_deb;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_deb & ~r_deb_q;
endmodule

module chess_clock_turn_ctrl #(
  parameter int p_debounce = 1_000_000
) (
  input  logic       i_clk_50m,
  input  logic       i_rst,
  input  logic       i_btn_a,
  input  logic       i_btn_b,
  input  logic       i_btn_pause,
  input  logic       i_flag_a,
  input  logic       i_flag_b,
  output logic       o_sw_turn,
  output logic       o_run,
  output logic [3:0] o_led,
  output logic [7:0] o_moves,
  output logic       o_loser
);
`ifdef CHESS_CLOCK_PAUSE_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_A,
    S_RUN_B,
    S_DONE
`ifdef CHESS_CLOCK_PAUSE_EN
    , S_PAUSE_A,
    S_PAUSE_B
`endif
  } state_t;

  logic [NBTN-1:0] w_raw, w_press;
  logic            w_press_a, w_press_b;

  assign w_raw[0] = i_btn_a;
  assign w_raw[1] = i_btn_b;
`ifdef CHESS_CLOCK_PAUSE_EN
  logic w_press_p;
  assign w_raw[2]  = i_btn_pause;
  assign w_press_p = w_press[2];
`else
  logic w_unused_pause;
  assign w_unused_pause = i_btn_pause;
`endif
  assign w_press_a = w_press[0];
  assign w_press_b = w_press[1];

  for (genvar g = 0; g < NBTN; g++) begin : g_db
    chess_clock_debounce #(.p_debounce(p_debounce)) u_db (
      .i_clk   (i_clk_50m),
      .i_rst   (i_rst),
      .i_raw   (w_raw[g]),
      .o_press (w_press[g])
    );
  end

  state_t     r_state, w_next;
  logic [7:0] r_moves;
  logic       r_loser;
  logic       w_move_inc, w_lose_set, w_lose_val;
  logic       w_run, w_turn;
  logic [3:0] w_led;

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Priority inside each running state: flag, then pause, then move press.
  always_comb begin
    w_next     = r_state;
    w_move_inc = 1'b0;
    w_lose_set = 1'b0;
    w_lose_val = 1'b0;
    w_run      = 1'b0;
    w_turn     = 1'b0;
    w_led      = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_press_b) w_next = S_RUN_A;
      end
      S_RUN_A: begin
        w_run  = 1'b1;
        w_led  = 4'b0001;
        if (i_flag_a) begin
          w_next     = S_DONE;
          w_lose_set = 1'b1;
          w_lose_val = 1'b0;
        end
`ifdef CHESS_CLOCK_PAUSE_EN
        else if (w_press_p) w_next = S_PAUSE_A;
`endif
        else if (w_press_a) w_next = S_RUN_B;
      end
      S_RUN_B: begin
        w_run  = 1'b1;
        w_turn = 1'b1;
        w_led  = 4'b0010;
        if (i_flag_b) begin
          w_next     = S_DONE;
          w_lose_set = 1'b1;
          w_lose_val = 1'b1;
        end
`ifdef CHESS_CLOCK_PAUSE_EN
        else if (w_press_p) w_next = S_PAUSE_B;
`endif
        else if (w_press_b) begin
          w_next     = S_RUN_A;
          w_move_inc = 1'b1;
        end
      end
`ifdef CHESS_CLOCK_PAUSE_EN
      S_PAUSE_A: begin
        w_led = 4'b0101;
        if (w_press_p) w_next = S_RUN_A;
      end
      S_PAUSE_B: begin
        w_turn = 1'b1;
        w_led  = 4'b0110;
        if (w_press_p) w_next = S_RUN_B;
      end
`endif
      S_DONE: begin
        w_turn = r_loser;
        w_led  = r_loser ? 4'b1010 : 4'b1001;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      r_moves <= 8'd0;
      r_loser <= 1'b0;
    end else begin
      if (w_move_inc && r_moves != 8'hFF) r_moves <= r_moves + 8'd1;
      if (w_lose_set)                      r_loser <= w_lose_val;
    end
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      o_sw_turn <= 1'b0;
      o_run     <= 1'b0;
      o_led     <= 4'b0000;
      o_moves   <= 8'd0;
      o_loser   <= 1'b0;
    end else begin
      o_sw_turn <= w_turn;
      o_run     <= w_run;
      o_led     <= w_led;
      o_moves   <= r_moves;
      o_loser   <= r_loser;
    end
  end
endmodule
